// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the CORDIC request scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cordic_pkg;

    // Datapath geometry of the shared arctan CORDIC pipeline.
    localparam int CORDIC_DATA_W  = 32;
    localparam int CORDIC_LATENCY = 12;

    // Q2.30 angle format: 1.0 = 2^30, pi/2 = 0x6487ED51.
    localparam int                         CORDIC_FRAC_W  = 30;
    localparam logic [CORDIC_DATA_W-1:0]   CORDIC_HALF_PI = 32'h6487_ED51;

    // Default requester count and per-requester in-flight limit.
    localparam int N_REQ_DEF   = 4;
    localparam int MAX_OUT_DEF = 4;

    // Requester index width; the tag and rsp_id are sized from this.
    localparam int ID_W = $clog2(N_REQ_DEF);

    // Tag that travels alongside each operand through the pipeline.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic            neg;
    } tag_t;

endpackage

// File: rtl/cordic_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index at or after the pointer.
// Latency: grant is combinational; pointer advances on the clock edge after a grant.
// Backpressure: none internally; an ineligible requester is simply skipped.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] elig_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Search from the pointer, wrapping, and pick the first eligible requester.
    always_comb begin
        int cand;
        cand      = 0;
        gnt_o     = '0;
        gnt_vld_o = 1'b0;
        gnt_idx_o = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr_q) + off) % N_REQ;
            if (!gnt_vld_o && elig_i[cand]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IDX_W'(cand);
            end
        end
        if (gnt_vld_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

    // Next pointer: one past the winner, or hold when nobody was granted.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld_o) begin
            if (int'(gnt_idx_o) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx_o + IDX_W'(1);
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cordic_req_scheduler.sv
// Shares one pipelined arctan CORDIC among N_REQ requesters, sign-folding operands and restoring sign on return.
// Latency: LATENCY+1 cycles from accepted request to rsp_valid; one issue and one result per cycle.
// Backpressure: req_ready withheld from requesters at MAX_OUT in flight; responses cannot be stalled.
module cordic_req_scheduler
    import cordic_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int DATA_W  = CORDIC_DATA_W,
    parameter int LATENCY = CORDIC_LATENCY,
    parameter int MAX_OUT = MAX_OUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]       cordic_g,
    input  logic [DATA_W-1:0]       cordic_z,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt;
    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_idx;

    logic [DATA_W-1:0] op;
    logic [DATA_W-1:0] cordic_g_q, cordic_g_d;
    tag_t              tag_q [LATENCY];
    tag_t              tag_in;
    tag_t              tail;

    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;

    logic [CNT_W-1:0]  cnt_q [N_REQ];
    logic [CNT_W-1:0]  cnt_d [N_REQ];

    // A requester may compete only while it has room for another result in flight.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .elig_i    (elig),
        .gnt_o     (gnt),
        .gnt_vld_o (gnt_vld),
        .gnt_idx_o (gnt_idx)
    );

    assign req_ready = gnt;

    // Fold the granted operand to its magnitude; the most negative value saturates
    // since its magnitude is not representable. The sign rides along in the tag.
    always_comb begin
        op         = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
        cordic_g_d = cordic_g_q;
        tag_in     = '0;
        if (gnt_vld) begin
            if (op == MIN_NEG) begin
                cordic_g_d = MAX_POS;
            end else if (op[DATA_W-1]) begin
                cordic_g_d = {DATA_W{1'b0}} - op;
            end else begin
                cordic_g_d = op;
            end
            tag_in.valid = 1'b1;
            tag_in.id    = gnt_idx;
            tag_in.neg   = op[DATA_W-1];
        end
    end

    // The last tag stage lines up with cordic_z; restore the sign and route to its owner.
    always_comb begin
        tail        = tag_q[LATENCY-1];
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (tail.valid) begin
            rsp_valid_d[tail.id] = 1'b1;
            rsp_id_d             = tail.id;
            rsp_data_d           = tail.neg ? ({DATA_W{1'b0}} - cordic_z) : cordic_z;
        end
    end

    // In-flight counters: +1 on issue, -1 as the response is registered, net zero when both.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && !(tail.valid && tail.id == ID_W'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!gnt[i] && tail.valid && tail.id == ID_W'(i)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // Issue register, tag shift pipe, response registers and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cordic_g_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            for (int j = 0; j < LATENCY; j++) begin
                tag_q[j] <= '0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cordic_g_q  <= cordic_g_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            tag_q[0]    <= tag_in;
            for (int j = 1; j < LATENCY; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Busy while any tag is in the pipe or a response is on the output.
    always_comb begin
        busy = |rsp_valid_q;
        for (int j = 0; j < LATENCY; j++) begin
            busy = busy | tag_q[j].valid;
        end
    end

    assign cordic_g  = cordic_g_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Self-checking bench for cordic_req_scheduler with a delay-line CORDIC stub (z = g >>> 1).
// Latency: stub returns z in the cycle the matching tag reaches the last stage.
// Backpressure: bench always sinks responses.
module tb_cordic_req_scheduler;
    import cordic_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic [W-1:0]     cordic_g;
    logic [W-1:0]     cordic_z;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_data;
    logic [ID_W-1:0]  rsp_id;
    logic             busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_req_scheduler #(
        .N_REQ   (N),
        .DATA_W  (W),
        .LATENCY (LAT),
        .MAX_OUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cordic_g  (cordic_g),
        .cordic_z  (cordic_z),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // CORDIC stand-in: cordic_g is already one register deep, so LAT-1 more stages
    // put z in the same cycle as the last tag stage.
    logic [W-1:0] dly [LAT-1];
    always_ff @(posedge clk) begin
        dly[0] <= cordic_g;
        for (int k = 1; k < LAT-1; k++) begin
            dly[k] <= dly[k-1];
        end
    end
    assign cordic_z = W'($signed(dly[LAT-2]) >>> 1);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int          id;
        logic [31:0] data;
        logic [31:0] exp_g;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t        vecs [7];
    logic [3:0]  one = 4'b0001;
    logic [3:0]  exp_oh;
    int          nrsp;
    int          ghost;
    int          first;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 32'h0040_0000, 32'h0040_0000, 32'h0020_0000};
        vecs[1] = '{2, 32'hFFC0_0000, 32'h0040_0000, 32'hFFE0_0000};
        vecs[2] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0001};
        vecs[3] = '{3, 32'h1234_5678, 32'h1234_5678, 32'h091A_2B3C};
        vecs[4] = '{3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[5] = '{1, 32'(1) << CORDIC_FRAC_W, 32'h4000_0000, 32'h2000_0000};
        vecs[6] = '{2, 32'h0 - CORDIC_HALF_PI, 32'h6487_ED51, 32'hCDBC_0958};

        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Single-request table: grant, issue value, response timing and sign restore.
        for (int v = 0; v < 7; v++) begin
            exp_oh = one << vecs[v].id;
            @(negedge clk);
            req_data                   = '0;
            req_data[vecs[v].id*W +: W] = vecs[v].data;
            req_valid                  = exp_oh;
            #1 chk("single_grant", 32'(req_ready), 32'(exp_oh));
            @(negedge clk);
            req_valid = '0;
            #1 chk("issue_g", cordic_g, vecs[v].exp_g);
            chk("busy_in_flight", 32'(busy), 32'd1);
            repeat (11) @(negedge clk);
            #1 chk("no_early_rsp", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            #1 chk("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
            chk("rsp_id", 32'(rsp_id), 32'(vecs[v].id));
            chk("rsp_data", rsp_data, vecs[v].exp_rsp);
            @(negedge clk);
            #1 chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
            chk("busy_idle", 32'(busy), 32'd0);
            chk("g_holds", cordic_g, vecs[v].exp_g);
        end

        // Fairness: all four requesters held for 16 cycles.
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = 32'(i + 1) << 20;
        end
        nrsp = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            req_valid = (c < 16) ? 4'hF : 4'h0;
            #1;
            if (c < 16) chk("rr_grant", 32'(req_ready), 32'(one << (c % 4)));
            if (rsp_valid != '0) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'(one << (nrsp % 4)));
                chk("rr_rsp_id", 32'(rsp_id), 32'(nrsp % 4));
                chk("rr_rsp_data", rsp_data, 32'((nrsp % 4) + 1) << 19);
                nrsp++;
            end
        end
        chk("rr_rsp_count", 32'(nrsp), 32'd16);

        // MAX_OUT: requester 3 alone saturates its in-flight budget.
        do_reset();
        req_data = '0;
        req_data[3*W +: W] = 32'h0008_0000;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            req_valid = 4'b1000;
            #1 chk("maxout_grant", 32'(req_ready), (c < 4 || c == 13) ? 32'h8 : 32'h0);
            if (c == 13) chk("maxout_rsp", 32'(rsp_valid), 32'h8);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (20) @(negedge clk);

        // Reset while six operations are in flight.
        do_reset();
        req_data = '0;
        req_data[0*W +: W] = 32'h0010_0000;
        req_data[1*W +: W] = 32'hFFF0_0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = 4'b0011;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_g", cordic_g, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ghost = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != '0) ghost++;
        end
        chk("no_ghost_rsp", 32'(ghost), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Counters must be back at zero: four back-to-back grants, then blocked.
        first = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            req_valid = (c < 5) ? 4'b0001 : 4'b0000;
            #1;
            if (c < 5) chk("post_rst_grant", 32'(req_ready), (c < 4) ? 32'h1 : 32'h0);
            if (rsp_valid != '0 && first < 0) first = c;
        end
        chk("post_rst_latency", 32'(first), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
